motor_speed_regulator: RTL and testbench
========================================

# motor_speed_regulator

Parametrised closed-loop spin-motor regulator for the rotating module. It measures rotor speed from a slotted opto-switch and drives a PWM duty cycle that holds one revolution at a runtime-programmable clock-cycle count. It adds a spin-up phase, lock/unlock hysteresis, stall detection, and a per-revolution period report for the ranging pipeline.

## Interface
Parameters:
- TEETH, 39: opto edges per revolution (≥2).
- PWM_PERIOD, 1000: PWM counter modulus in clock cycles.
- DUTY_W, 16: duty width.
- DUTY_MIN / DUTY_MAX, 30 / 980: duty clamp.
- SPIN_DUTY, 980: duty held during spin-up.
- REV_W, 30: revolution counter width.
- COARSE_SHIFT / LOCK_SHIFT, 3 / 6: error windows, equal to target>>shift.
- STEP_COARSE, 5: duty step outside the coarse window.
- LOCK_REVS / UNLOCK_REVS, 6 / 200: consecutive revolutions needed to lock / to unlock.
- STALL_CYC, 50_000_000: maximum gap between edges.
- RETRY_CYC, 250_000_000: fault back-off before retry (used only with the macro).

Ports:
- i_clk_50m  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_enable  in  1  motor run request (measure mode).
- i_cal_mode  in  1  calibration; motor off, edges ignored.
- i_opto_switch  in  1  asynchronous opto input.
- i_target_rev  in  REV_W  target cycles per revolution.
- i_duty_init  in  DUTY_W  duty loaded on leaving spin-up.
- o_motor_pwm  out  1  PWM drive.
- o_duty  out  DUTY_W  current duty.
- o_rev_period  out  REV_W  last measured revolution length.
- o_rev_valid  out  1  one-cycle strobe marking a new o_rev_period.
- o_locked  out  1  speed in window (forced 1 in calibration).
- o_fault  out  1  stall detected.
- o_state  out  3  FSM state.

## Operation
- **Opto path.** 2-flop synchroniser plus one previous-value flop. rise = sync & ~prev.
- **Calibration.** While i_cal_mode=1, the synchroniser is forced to 1, so no edges are seen.
- **Tooth counter.** Counts 0..TEETH-1. A rise at TEETH-1 is a *rev event*, and the counter wraps to 0.
- **Revolution counter.** Increments every cycle, saturates at 2^REV_W-1, and clears on a rev event.
- **Rev event outputs.** On a rev event, o_rev_period takes the pre-clear count and o_rev_valid is pulsed.
- **Windows.** Computed at each rev event from i_target_rev:
  - hiC = T + (T>>COARSE_SHIFT)
  - hiL = T + (T>>LOCK_SHIFT)
  - loL = T - (T>>LOCK_SHIFT)
- **Width rule.** Comparisons use REV_W+1 bits, so hiC cannot overflow.
- **FSM states.** IDLE=0, SPINUP=1, REGULATE=2, LOCKED=3, FAULT=4.
- **IDLE.**
  - Duty is 0 and the PWM counter is held at 0.
  - Tooth, rev, lock and miss counters are cleared.
  - Leaves to SPINUP when i_enable=1 and i_cal_mode=0.
- **SPINUP.**
  - Duty is SPIN_DUTY.
  - A rev event with period ≤ hiC loads duty=i_duty_init and moves to REGULATE.
- **REGULATE / LOCKED, on each rev event** (P = measured period):
  - P > hiC: duty += STEP_COARSE.
  - Else P > hiL: duty += 1.
  - Else P < loL: duty -= 1.
  - Otherwise duty holds.
  - Duty always saturates to [DUTY_MIN, DUTY_MAX].
- **Locking.**
  - An in-window revolution (loL ≤ P ≤ hiL) increments the lock counter; any other revolution clears it.
  - When the lock counter reaches LOCK_REVS, REGULATE moves to LOCKED.
  - In LOCKED, consecutive out-of-window revolutions count misses. Reaching UNLOCK_REVS moves to REGULATE. Any in-window revolution clears the miss counter.
- **Stall.**
  - The gap counter clears on every rise and saturates.
  - In SPINUP, REGULATE or LOCKED, gap = STALL_CYC moves to FAULT: o_fault=1, duty 0.
- **Global exits.** From any state, i_enable=0 or i_cal_mode=1 moves to IDLE on the next cycle. This takes priority over everything, including the rev event and the stall.
- **o_locked.** Equals (state==LOCKED) | i_cal_mode.
- **Target change.** A new i_target_rev is used at the next rev event. No state is forced.
- **PWM.** The counter runs 0..PWM_PERIOD-1. o_motor_pwm is registered as (cnt < duty) and is 0 in IDLE and FAULT.

## Timing
- Reset values:
  - o_motor_pwm=0, o_duty=0, o_rev_period=0, o_rev_valid=0, o_locked=0, o_fault=0, o_state=IDLE.
  - All counters 0; synchroniser flops 1.
- Latency:
  - i_opto_switch rise to o_rev_valid: 3 cycles.
  - Duty update and state transition occur in the same cycle as o_rev_valid.
  - o_motor_pwm reflects a new duty 1 cycle later.
- Simultaneous events:
  - A rise in the same cycle as the gap reaching STALL_CYC: the rise wins, no fault.
  - A rev event in the cycle i_enable falls: IDLE wins.
  - The period is still reported whenever i_enable=1.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous assertion).
- Duty at the bounds never wraps; for example duty=978 with +5 gives 980.

## Configuration
- MOTOR_REG_STALL_RETRY_EN defined: FAULT counts RETRY_CYC cycles, then clears o_fault and enters SPINUP.
- Macro absent: FAULT is held until i_enable=0 or i_cal_mode=1 (IDLE); RETRY_CYC is unused.

## Structure
- Package motor_reg_pkg: state encoding constants (IDLE..FAULT) and the default parameter values.
- Sub-module motor_opto_meter: synchroniser, tooth counter, revolution counter and gap counter. Outputs are rise, rev_event, period and stall.
- Top level keeps the FSM, duty arithmetic and PWM.

## Test plan
Bench parameters: TEETH=4, PWM_PERIOD=10, STALL_CYC=2000, LOCK_REVS=3, UNLOCK_REVS=2, target=400.
1. Reset, enable, edges every 100 cycles: IDLE→SPINUP, duty=980, o_rev_period=400 → REGULATE with duty=i_duty_init; after 3 in-window revolutions, o_locked=1.
2. In REGULATE with duty=500:
   - period 460 (> hiC=450) → duty=505.
   - period 420 (> hiL=406) → 506.
   - period 380 (< 394) → 505.
   - period 400 → 505.
3. Duty=978 with period 500 → 980, not 983. Duty=30 with period 300 → stays 30.
4. LOCKED, then two revolutions at period 420 → REGULATE, o_locked=0. Edges stop for 2000 cycles → FAULT, o_motor_pwm=0; retry behaviour per the macro.
5. i_cal_mode=1 mid-LOCKED: next cycle IDLE, o_locked=1, pwm 0, opto edges ignored. Async i_rst mid-revolution: all outputs 0 at once.

Source files
------------

// File: rtl/motor_reg_pkg.sv
// rtl/motor_reg_pkg.sv - state encoding and default parameters for the spin-motor regulator
package motor_reg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SPINUP   = 3'd1,
        ST_REGULATE = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    localparam int DEF_TEETH        = 39;
    localparam int DEF_PWM_PERIOD   = 1000;
    localparam int DEF_DUTY_W       = 16;
    localparam int DEF_DUTY_MIN     = 30;
    localparam int DEF_DUTY_MAX     = 980;
    localparam int DEF_SPIN_DUTY    = 980;
    localparam int DEF_REV_W        = 30;
    localparam int DEF_COARSE_SHIFT = 3;
    localparam int DEF_LOCK_SHIFT   = 6;
    localparam int DEF_STEP_COARSE  = 5;
    localparam int DEF_LOCK_REVS    = 6;
    localparam int DEF_UNLOCK_REVS  = 200;
    localparam int DEF_STALL_CYC    = 50_000_000;
    localparam int DEF_RETRY_CYC    = 250_000_000;

endpackage

// File: rtl/motor_opto_meter.sv
// rtl/motor_opto_meter.sv - opto synchroniser, tooth/revolution/gap counters
module motor_opto_meter
    import motor_reg_pkg::*;
#(
    parameter int TEETH     = DEF_TEETH,
    parameter int REV_W     = DEF_REV_W,
    parameter int STALL_CYC = DEF_STALL_CYC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cal_mode,
    input  logic             opto_switch,
    output logic             rise,
    output logic             rev_event,
    output logic [REV_W-1:0] period,
    output logic             stall
);

    localparam int TOOTH_W = $clog2(TEETH);
    localparam int GAP_W   = $clog2(STALL_CYC + 1);
    localparam logic [TOOTH_W-1:0] TOOTH_LAST = TOOTH_W'(TEETH - 1);
    localparam logic [GAP_W-1:0]   GAP_LIMIT  = GAP_W'(STALL_CYC);
    localparam logic [REV_W-1:0]   REV_MAX    = '1;

    logic               sync_a, sync_b, prev;
    logic [TOOTH_W-1:0] tooth;
    logic [REV_W-1:0]   rev_cnt;
    logic [GAP_W-1:0]   gap;

    // Calibration parks the whole chain high so no rising edge can appear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst || cal_mode) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            prev   <= 1'b1;
        end else begin
            sync_a <= opto_switch;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign rise      = sync_b & ~prev;
    assign rev_event = rise && (tooth == TOOTH_LAST) && !clr;
    // The event cycle itself belongs to the revolution being closed.
    assign period    = (rev_cnt == REV_MAX) ? REV_MAX : rev_cnt + REV_W'(1);
    assign stall     = (gap == GAP_LIMIT) && !clr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tooth   <= '0;
            rev_cnt <= '0;
            gap     <= '0;
        end else if (clr) begin
            tooth   <= '0;
            rev_cnt <= '0;
            gap     <= '0;
        end else begin
            if (rise)
                tooth <= (tooth == TOOTH_LAST) ? '0 : tooth + TOOTH_W'(1);
            if (rev_event)
                rev_cnt <= '0;
            else if (rev_cnt != REV_MAX)
                rev_cnt <= rev_cnt + REV_W'(1);
            if (rise)
                gap <= '0;
            else if (gap != GAP_LIMIT)
                gap <= gap + GAP_W'(1);
        end
    end

endmodule

// File: rtl/motor_speed_regulator.sv
// rtl/motor_speed_regulator.sv - closed-loop spin regulator FSM, duty loop, PWM; MOTOR_REG_STALL_RETRY_EN enables fault retry
module motor_speed_regulator
    import motor_reg_pkg::*;
#(
    parameter int TEETH        = DEF_TEETH,
    parameter int PWM_PERIOD   = DEF_PWM_PERIOD,
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int DUTY_MIN     = DEF_DUTY_MIN,
    parameter int DUTY_MAX     = DEF_DUTY_MAX,
    parameter int SPIN_DUTY    = DEF_SPIN_DUTY,
    parameter int REV_W        = DEF_REV_W,
    parameter int COARSE_SHIFT = DEF_COARSE_SHIFT,
    parameter int LOCK_SHIFT   = DEF_LOCK_SHIFT,
    parameter int STEP_COARSE  = DEF_STEP_COARSE,
    parameter int LOCK_REVS    = DEF_LOCK_REVS,
    parameter int UNLOCK_REVS  = DEF_UNLOCK_REVS,
    parameter int STALL_CYC    = DEF_STALL_CYC,
    parameter int RETRY_CYC    = DEF_RETRY_CYC
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_cal_mode,
    input  logic              i_opto_switch,
    input  logic [REV_W-1:0]  i_target_rev,
    input  logic [DUTY_W-1:0] i_duty_init,
    output logic              o_motor_pwm,
    output logic [DUTY_W-1:0] o_duty,
    output logic [REV_W-1:0]  o_rev_period,
    output logic              o_rev_valid,
    output logic              o_locked,
    output logic              o_fault,
    output logic [2:0]        o_state
);

    localparam int LOCK_W = $clog2(LOCK_REVS + 1);
    localparam int MISS_W = $clog2(UNLOCK_REVS + 1);
    localparam logic [DUTY_W-1:0] PWM_LAST = DUTY_W'(PWM_PERIOD - 1);

    state_t              state;
    logic [DUTY_W-1:0]   duty, duty_next, pwm_cnt;
    logic [REV_W-1:0]    rev_period, period;
    logic                rev_valid, fault, pwm;
    logic [LOCK_W-1:0]   lock_cnt;
    logic [MISS_W-1:0]   miss_cnt;
    logic                clr, rise, rev_event, stall;
    logic [REV_W:0]      tgt, per, hi_c, hi_l, lo_l;
    logic                over_c, over_l, under_l, in_win;
    int                  duty_calc;
`ifdef MOTOR_REG_STALL_RETRY_EN
    localparam int RETRY_W = $clog2(RETRY_CYC + 1);
    logic [RETRY_W-1:0]  retry_cnt;
`endif

    assign clr = (state == ST_IDLE) || (state == ST_FAULT);

    motor_opto_meter #(
        .TEETH     (TEETH),
        .REV_W     (REV_W),
        .STALL_CYC (STALL_CYC)
    ) u_meter (
        .clk         (i_clk_50m),
        .rst         (i_rst),
        .clr         (clr),
        .cal_mode    (i_cal_mode),
        .opto_switch (i_opto_switch),
        .rise        (rise),
        .rev_event   (rev_event),
        .period      (period),
        .stall       (stall)
    );

    // One extra bit keeps target + target>>shift from wrapping.
    assign tgt     = {1'b0, i_target_rev};
    assign per     = {1'b0, period};
    assign hi_c    = tgt + (tgt >> COARSE_SHIFT);
    assign hi_l    = tgt + (tgt >> LOCK_SHIFT);
    assign lo_l    = tgt - (tgt >> LOCK_SHIFT);
    assign over_c  = per > hi_c;
    assign over_l  = per > hi_l;
    assign under_l = per < lo_l;
    assign in_win  = !over_l && !under_l;

    always_comb begin
        duty_calc = int'(duty);
        if (over_c)
            duty_calc = duty_calc + STEP_COARSE;
        else if (over_l)
            duty_calc = duty_calc + 1;
        else if (under_l)
            duty_calc = duty_calc - 1;
        if (duty_calc > DUTY_MAX)
            duty_next = DUTY_W'(DUTY_MAX);
        else if (duty_calc < DUTY_MIN)
            duty_next = DUTY_W'(DUTY_MIN);
        else
            duty_next = DUTY_W'(duty_calc);
    end

    always_ff @(posedge i_clk_50m or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            duty       <= '0;
            rev_period <= '0;
            rev_valid  <= 1'b0;
            fault      <= 1'b0;
            pwm        <= 1'b0;
            pwm_cnt    <= '0;
            lock_cnt   <= '0;
            miss_cnt   <= '0;
`ifdef MOTOR_REG_STALL_RETRY_EN
            retry_cnt  <= '0;
`endif
        end else begin
            rev_valid <= rev_event && i_enable;
            if (rev_event && i_enable)
                rev_period <= period;
            pwm_cnt <= (state == ST_IDLE || pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + DUTY_W'(1);
            pwm     <= pwm_cnt < duty;
`ifdef MOTOR_REG_STALL_RETRY_EN
            retry_cnt <= '0;
`endif
            // Global exits outrank rev events and stalls alike.
            if (!i_enable || i_cal_mode) begin
                state    <= ST_IDLE;
                duty     <= '0;
                fault    <= 1'b0;
                pwm      <= 1'b0;
                lock_cnt <= '0;
                miss_cnt <= '0;
            end else if (stall && !rise) begin
                state <= ST_FAULT;
                duty  <= '0;
                fault <= 1'b1;
                pwm   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state <= ST_SPINUP;
                        duty  <= DUTY_W'(SPIN_DUTY);
                    end
                    ST_SPINUP: begin
                        if (rev_event && !over_c) begin
                            state    <= ST_REGULATE;
                            duty     <= i_duty_init;
                            lock_cnt <= '0;
                        end
                    end
                    ST_REGULATE: begin
                        if (rev_event) begin
                            duty <= duty_next;
                            if (!in_win) begin
                                lock_cnt <= '0;
                            end else if (lock_cnt == LOCK_W'(LOCK_REVS - 1)) begin
                                state    <= ST_LOCKED;
                                lock_cnt <= '0;
                                miss_cnt <= '0;
                            end else begin
                                lock_cnt <= lock_cnt + LOCK_W'(1);
                            end
                        end
                    end
                    ST_LOCKED: begin
                        if (rev_event) begin
                            duty <= duty_next;
                            if (in_win) begin
                                miss_cnt <= '0;
                            end else if (miss_cnt == MISS_W'(UNLOCK_REVS - 1)) begin
                                state    <= ST_REGULATE;
                                miss_cnt <= '0;
                                lock_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + MISS_W'(1);
                            end
                        end
                    end
                    ST_FAULT: begin
                        pwm <= 1'b0;
`ifdef MOTOR_REG_STALL_RETRY_EN
                        if (retry_cnt == RETRY_W'(RETRY_CYC - 1)) begin
                            state <= ST_SPINUP;
                            fault <= 1'b0;
                            duty  <= DUTY_W'(SPIN_DUTY);
                        end else begin
                            retry_cnt <= retry_cnt + RETRY_W'(1);
                        end
`else
                        state <= ST_FAULT;
`endif
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_motor_pwm  = pwm;
    assign o_duty       = duty;
    assign o_rev_period = rev_period;
    assign o_rev_valid  = rev_valid;
    assign o_locked     = (state == ST_LOCKED) | i_cal_mode;
    assign o_fault      = fault;
    assign o_state      = state;

endmodule

// File: tb/tb_motor_speed_regulator.sv
// tb/tb_motor_speed_regulator.sv - directed self-checking bench for motor_speed_regulator
module tb_motor_speed_regulator;

    localparam int REV_W  = 30;
    localparam int DUTY_W = 16;
    localparam int HIGH   = 10;

    logic              clk = 1'b0;
    logic              rst, enable, cal_mode, opto;
    logic [REV_W-1:0]  target_rev;
    logic [DUTY_W-1:0] duty_init;
    logic              motor_pwm, rev_valid, locked, fault;
    logic [DUTY_W-1:0] duty;
    logic [REV_W-1:0]  rev_period;
    logic [2:0]        state;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int rev_seen = 0;
    int n0;

    always #5 clk = ~clk;

    motor_speed_regulator #(
        .TEETH(4), .PWM_PERIOD(10), .DUTY_W(DUTY_W), .DUTY_MIN(30), .DUTY_MAX(980),
        .SPIN_DUTY(980), .REV_W(REV_W), .COARSE_SHIFT(3), .LOCK_SHIFT(6),
        .STEP_COARSE(5), .LOCK_REVS(3), .UNLOCK_REVS(2), .STALL_CYC(2000), .RETRY_CYC(3000)
    ) dut (
        .i_clk_50m     (clk),
        .i_rst         (rst),
        .i_enable      (enable),
        .i_cal_mode    (cal_mode),
        .i_opto_switch (opto),
        .i_target_rev  (target_rev),
        .i_duty_init   (duty_init),
        .o_motor_pwm   (motor_pwm),
        .o_duty        (duty),
        .o_rev_period  (rev_period),
        .o_rev_valid   (rev_valid),
        .o_locked      (locked),
        .o_fault       (fault),
        .o_state       (state)
    );

    always @(negedge clk) if (rev_valid) rev_seen++;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Rising edge sits HIGH cycles before the end of each tooth, so back-to-back
    // revolutions of tooth spacing g measure exactly 4*g cycles.
    task automatic tooth(input int g);
        opto = 1'b0;
        repeat (g - HIGH) @(negedge clk);
        opto = 1'b1;
        repeat (HIGH) @(negedge clk);
    endtask

    task automatic rev(input int g);
        repeat (4) tooth(g);
    endtask

    task automatic rev_chk(input string tag, input int g, input int exp_period,
                           input int exp_duty, input int exp_state);
        int s0;
        s0 = rev_seen;
        rev(g);
        check_vec({tag, "_strobe"}, rev_seen - s0, 1);
        if (exp_period >= 0) check_vec({tag, "_period"}, rev_period, exp_period);
        check_vec({tag, "_duty"}, duty, exp_duty);
        check_vec({tag, "_state"}, state, exp_state);
    endtask

    task automatic wait_state(input string tag, input int st, input int limit);
        int n;
        n = 0;
        while (state != st && n < limit) begin
            @(negedge clk);
            n++;
        end
        check_vec(tag, state, st);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; cal_mode = 1'b0; opto = 1'b0;
        target_rev = 400; duty_init = 500;
        repeat (3) @(negedge clk);
        check_vec("rst_state", state, 0);
        check_vec("rst_duty", duty, 0);
        check_vec("rst_pwm", motor_pwm, 0);
        check_vec("rst_period", rev_period, 0);
        check_vec("rst_valid", rev_valid, 0);
        check_vec("rst_locked", locked, 0);
        check_vec("rst_fault", fault, 0);
        rst = 1'b0;
        @(negedge clk);

        enable = 1'b1;
        @(negedge clk);
        check_vec("spin_state", state, 1);
        check_vec("spin_duty", duty, 980);
        rev_chk("spin", 100, -1, 500, 2);

        // T=400: hiC=450 hiL=406 loL=394
        rev_chk("coarse", 115, 460, 505, 2);
        rev_chk("fine_up", 105, 420, 506, 2);
        rev_chk("fine_dn", 95, 380, 505, 2);
        rev_chk("hold", 100, 400, 505, 2);
        rev_chk("lock2", 100, 400, 505, 2);
        rev_chk("lock3", 100, 400, 505, 3);
        check_vec("locked_on", locked, 1);
        rev_chk("miss1", 105, 420, 506, 3);
        rev_chk("miss2", 105, 420, 507, 2);
        check_vec("locked_off", locked, 0);

        opto = 1'b0;
        repeat (1800) @(negedge clk);
        check_vec("pre_stall", state, 2);
        wait_state("stall_state", 4, 500);
        check_vec("stall_fault", fault, 1);
        check_vec("stall_pwm", motor_pwm, 0);
        check_vec("stall_duty", duty, 0);
        repeat (1000) @(negedge clk);
        check_vec("fault_hold", state, 4);
`ifdef MOTOR_REG_STALL_RETRY_EN
        wait_state("retry_state", 1, 2500);
        check_vec("retry_fault", fault, 0);
`endif
        enable = 1'b0;
        @(negedge clk);
        check_vec("exit_state", state, 0);
        check_vec("exit_fault", fault, 0);

        duty_init = 978;
        enable = 1'b1;
        @(negedge clk);
        rev_chk("spin978", 100, -1, 978, 2);
        rev_chk("sat_hi", 125, 500, 980, 2);
        enable = 1'b0;
        @(negedge clk);
        duty_init = 30;
        enable = 1'b1;
        @(negedge clk);
        rev_chk("spin30", 100, -1, 30, 2);
        rev_chk("sat_lo", 75, 300, 30, 2);
        check_vec("pwm_on", motor_pwm, 1);

        rev_chk("relock1", 100, 400, 30, 2);
        rev_chk("relock2", 100, 400, 30, 2);
        rev_chk("relock3", 100, 400, 30, 3);
        cal_mode = 1'b1;
        @(negedge clk);
        check_vec("cal_state", state, 0);
        check_vec("cal_locked", locked, 1);
        check_vec("cal_pwm", motor_pwm, 0);
        check_vec("cal_duty", duty, 0);
        n0 = rev_seen;
        rev(100);
        rev(100);
        check_vec("cal_no_edges", rev_seen - n0, 0);
        check_vec("cal_idle", state, 0);
        cal_mode = 1'b0;
        @(negedge clk);
        check_vec("cal_exit", state, 1);
        rev_chk("respin", 100, -1, 30, 2);

        tooth(100);
        tooth(100);
        #2 rst = 1'b1;
        #1;
        check_vec("arst_state", state, 0);
        check_vec("arst_duty", duty, 0);
        check_vec("arst_pwm", motor_pwm, 0);
        check_vec("arst_period", rev_period, 0);
        check_vec("arst_valid", rev_valid, 0);
        check_vec("arst_locked", locked, 0);
        check_vec("arst_fault", fault, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
